// File: rtl/mesh_port_arbiter_if.sv
// Mesh port arbiter bus: per-channel producer side and merged
// consumer side of the port.
interface mesh_port_arbiter_if #(
  parameter int CHANNELS = 4,
  parameter int pckg_sz  = 40,
  parameter int SRC_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
  logic [CHANNELS-1:0]         push;
  logic [CHANNELS*pckg_sz-1:0] data_in;
  logic [CHANNELS-1:0]         full;
  logic [CHANNELS-1:0]         overflow;
  logic                        clr_ovf;
  logic                        pndng;
  logic [pckg_sz-1:0]          data_out;
  logic [SRC_W-1:0]            src_id;
  logic                        pop;

  modport master (
    output push, data_in, clr_ovf, pop,
    input  full, overflow, pndng, data_out, src_id
  );

  modport slave (
    input  push, data_in, clr_ovf, pop,
    output full, overflow, pndng, data_out, src_id
  );
endinterface

// File: rtl/mesh_port_arbiter.sv
// Merges CHANNELS buffered terminal inputs into one mesh port
// through a registered output stage with RR or fixed arbitration.
module mesh_port_arbiter #(
  parameter int CHANNELS   = 4,
  parameter int pckg_sz    = 40,
  parameter int fifo_depth = 4,
  parameter int ARB_MODE   = 0
) (
  input  logic clk,
  input  logic reset,
  mesh_port_arbiter_if.slave bus
);
  localparam int SRC_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PTR_W = $clog2(fifo_depth);
  localparam int CNT_W = $clog2(fifo_depth + 1);

  typedef enum logic {EMPTY, VALID} state_t;

  state_t                      state;
  logic                        pndng_q;
  logic [pckg_sz-1:0]          data_q;
  logic [SRC_W-1:0]            src_q;
  logic [SRC_W-1:0]            rr;
  logic [CHANNELS-1:0]         ovf_q;
  logic [CHANNELS-1:0]         full_v;
  logic [CHANNELS-1:0]         nonempty;
  logic [CHANNELS-1:0]         rd_en;
  logic [CHANNELS-1:0]         wr_en;
  logic [CHANNELS-1:0]         drop;
  logic [CHANNELS*pckg_sz-1:0] heads;
  logic [SRC_W-1:0]            winner;
  logic                        any;
  logic                        load;

  function automatic logic [PTR_W-1:0] nxt(
    input logic [PTR_W-1:0] p
  );
    if (p == PTR_W'(fifo_depth - 1))
      return '0;
    return p + PTR_W'(1);
  endfunction

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [pckg_sz-1:0] mem [fifo_depth];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   cnt;

    assign full_v[i]   = (cnt == CNT_W'(fifo_depth));
    assign nonempty[i] = (cnt != '0);
    assign rd_en[i]    = load && (winner == SRC_W'(i));
    // A full FIFO still accepts when its head leaves this cycle.
    assign wr_en[i]    = bus.push[i] &&
                         (!full_v[i] || rd_en[i]);
    assign drop[i]     = bus.push[i] && full_v[i] &&
                         !rd_en[i];
    assign heads[i*pckg_sz +: pckg_sz] = mem[rd_ptr];

    always_ff @(posedge clk) begin
      if (!reset) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (wr_en[i])
          wr_ptr <= nxt(wr_ptr);
        if (rd_en[i])
          rd_ptr <= nxt(rd_ptr);
        cnt <= cnt + CNT_W'(wr_en[i]) - CNT_W'(rd_en[i]);
      end
    end

    always_ff @(posedge clk) begin
      if (reset && wr_en[i])
        mem[wr_ptr] <= bus.data_in[i*pckg_sz +: pckg_sz];
    end
  end

  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    any    = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (ARB_MODE == 1)
        idx = k;
      else
        idx = (int'(rr) + k) % CHANNELS;
      if (!any && nonempty[idx]) begin
        any    = 1'b1;
        winner = SRC_W'(idx);
      end
    end
  end

  assign load = any && (state == EMPTY || bus.pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= EMPTY;
      pndng_q <= 1'b0;
      data_q  <= '0;
      src_q   <= '0;
      rr      <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (load) begin
            state   <= VALID;
            pndng_q <= 1'b1;
          end
        end
        VALID: begin
          if (bus.pop && !any) begin
            state   <= EMPTY;
            pndng_q <= 1'b0;
          end
        end
        default: begin
          state   <= EMPTY;
          pndng_q <= 1'b0;
        end
      endcase
      if (load) begin
        data_q <= heads[int'(winner)*pckg_sz +: pckg_sz];
        src_q  <= winner;
        if (ARB_MODE == 0) begin
          if (int'(winner) == CHANNELS - 1)
            rr <= '0;
          else
            rr <= winner + SRC_W'(1);
        end
      end
    end
  end

  // Clear wins over a drop in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset)
      ovf_q <= '0;
    else if (bus.clr_ovf)
      ovf_q <= '0;
    else
      ovf_q <= ovf_q | drop;
  end

  assign bus.full     = full_v;
  assign bus.overflow = ovf_q;
  assign bus.pndng    = pndng_q;
  assign bus.data_out = data_q;
  assign bus.src_id   = src_q;
endmodule

// File: tb/tb_mesh_port_arbiter.sv
// Bench for mesh_port_arbiter: directed vector table on RR and
// fixed-priority instances, then random traffic against a queue model.
module tb_mesh_port_arbiter;
  localparam int CH = 4;
  localparam int PW = 40;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] push;
  logic [PW-1:0] d;
  logic          pop;
  logic          clr;
  logic [CH*PW-1:0] din;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    din = '0;
    for (int c = 0; c < CH; c++)
      din[c*PW +: PW] = d + PW'(c);
  end

  mesh_port_arbiter_if #(.CHANNELS(CH), .pckg_sz(PW)) bus0 ();
  mesh_port_arbiter_if #(.CHANNELS(CH), .pckg_sz(PW)) bus1 ();

  assign bus0.push    = push;
  assign bus0.data_in = din;
  assign bus0.clr_ovf = clr;
  assign bus0.pop     = pop;
  assign bus1.push    = push;
  assign bus1.data_in = din;
  assign bus1.clr_ovf = clr;
  assign bus1.pop     = pop;

  mesh_port_arbiter #(
    .CHANNELS(CH), .pckg_sz(PW),
    .fifo_depth(4), .ARB_MODE(0)
  ) dut (
    .clk(clk), .reset(rst_n), .bus(bus0)
  );

  mesh_port_arbiter #(
    .CHANNELS(CH), .pckg_sz(PW),
    .fifo_depth(4), .ARB_MODE(1)
  ) dut_fp (
    .clk(clk), .reset(rst_n), .bus(bus1)
  );

  // Reference: per-channel queues, a presented slot, a rr pointer.
  typedef logic [PW-1:0] pkt_q_t [$];
  pkt_q_t        mq [2*CH];
  bit            mv [2];
  logic [PW-1:0] md [2];
  int            ms [2];
  int            mrr [2];
  logic [CH-1:0] movf [2];

  task automatic model_step(input int m);
    int  w;
    bit  hit;
    bit  ld;
    int  sz [CH];
    int  c;
    if (!rst_n) begin
      for (int k = 0; k < CH; k++)
        mq[m*CH+k].delete();
      mv[m]   = 1'b0;
      md[m]   = '0;
      ms[m]   = 0;
      mrr[m]  = 0;
      movf[m] = '0;
      return;
    end
    for (int k = 0; k < CH; k++)
      sz[k] = mq[m*CH+k].size();
    hit = 1'b0;
    w   = 0;
    for (int k = 0; k < CH; k++) begin
      c = (m == 1) ? k : (mrr[m] + k) % CH;
      if (!hit && sz[c] > 0) begin
        hit = 1'b1;
        w   = c;
      end
    end
    ld = hit && (!mv[m] || pop);
    if (ld) begin
      md[m] = mq[m*CH+w].pop_front();
      ms[m] = w;
      mv[m] = 1'b1;
      if (m == 0)
        mrr[m] = (w + 1) % CH;
    end else if (mv[m] && pop) begin
      mv[m] = 1'b0;
    end
    for (int k = 0; k < CH; k++) begin
      if (push[k]) begin
        if (sz[k] < 4 || (ld && w == k))
          mq[m*CH+k].push_back(din[k*PW +: PW]);
        else
          movf[m][k] = 1'b1;
      end
    end
    if (clr)
      movf[m] = '0;
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic chk(input string nm,
                     input logic [PW-1:0] a,
                     input logic [PW-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  typedef struct {
    bit            sel;
    logic          rst;
    logic [CH-1:0] push;
    logic [PW-1:0] d;
    logic          pop;
    logic          clr;
    logic          ep;
    logic [PW-1:0] ed;
    int            es;
    logic [CH-1:0] ef;
    logic [CH-1:0] eo;
    bit            cd;
  } vec_t;

  vec_t tv [$];

  function automatic void mk(
    bit sel, logic rst, logic [CH-1:0] p,
    logic [PW-1:0] dv, logic po, logic cl,
    logic ep, logic [PW-1:0] ed, int es,
    logic [CH-1:0] ef, logic [CH-1:0] eo, bit cd
  );
    vec_t v;
    v.sel = sel; v.rst = rst; v.push = p;
    v.d = dv; v.pop = po; v.clr = cl;
    v.ep = ep; v.ed = ed; v.es = es;
    v.ef = ef; v.eo = eo; v.cd = cd;
    tv.push_back(v);
  endfunction

  initial begin
    logic          ap;
    logic [PW-1:0] ad;
    logic [1:0]    as;
    logic [CH-1:0] af;
    logic [CH-1:0] ao;
    logic [CH-1:0] mf;
    int            pp;

    rst_n = 1'b0; push = '0; d = '0;
    pop = 1'b0; clr = 1'b0;

    // single packet, then pop in EMPTY ignored
    mk(0,0,4'b0000,'h00,0,0, 0,'h00,0,4'b0000,4'b0000,1);
    mk(0,1,4'b0100,'hA3,0,0, 0,'h00,0,4'b0000,4'b0000,1);
    mk(0,1,4'b0000,'h00,0,0, 1,'hA5,2,4'b0000,4'b0000,1);
    mk(0,1,4'b0000,'h00,1,0, 0,'h00,0,4'b0000,4'b0000,0);
    mk(0,1,4'b0000,'h00,1,0, 0,'h00,0,4'b0000,4'b0000,0);
    // channel 1 fill, drop, clear, full with same-cycle read
    mk(0,1,4'b0010,'h10,0,0, 0,'h00,0,4'b0000,4'b0000,0);
    mk(0,1,4'b0010,'h11,0,0, 1,'h11,1,4'b0000,4'b0000,1);
    mk(0,1,4'b0010,'h12,0,0, 1,'h11,1,4'b0000,4'b0000,1);
    mk(0,1,4'b0010,'h13,0,0, 1,'h11,1,4'b0000,4'b0000,1);
    mk(0,1,4'b0010,'h14,0,0, 1,'h11,1,4'b0010,4'b0000,1);
    mk(0,1,4'b0010,'h15,0,0, 1,'h11,1,4'b0010,4'b0010,1);
    mk(0,1,4'b0000,'h00,0,1, 1,'h11,1,4'b0010,4'b0000,1);
    mk(0,1,4'b0010,'h16,1,0, 1,'h12,1,4'b0010,4'b0000,1);
    mk(0,1,4'b0000,'h00,1,0, 1,'h13,1,4'b0000,4'b0000,1);
    mk(0,1,4'b0000,'h00,1,0, 1,'h14,1,4'b0000,4'b0000,1);
    mk(0,1,4'b0000,'h00,1,0, 1,'h15,1,4'b0000,4'b0000,1);
    mk(0,1,4'b0000,'h00,1,0, 1,'h17,1,4'b0000,4'b0000,1);
    mk(0,1,4'b0000,'h00,1,0, 0,'h00,0,4'b0000,4'b0000,0);
    // round-robin over two packets per channel
    mk(0,0,4'b0000,'h00,0,0, 0,'h00,0,4'b0000,4'b0000,1);
    mk(0,1,4'b1111,'h20,0,0, 0,'h00,0,4'b0000,4'b0000,1);
    mk(0,1,4'b1111,'h30,0,0, 1,'h20,0,4'b0000,4'b0000,1);
    mk(0,1,4'b0000,'h00,1,0, 1,'h21,1,4'b0000,4'b0000,1);
    mk(0,1,4'b0000,'h00,1,0, 1,'h22,2,4'b0000,4'b0000,1);
    mk(0,1,4'b0000,'h00,1,0, 1,'h23,3,4'b0000,4'b0000,1);
    mk(0,1,4'b0000,'h00,1,0, 1,'h30,0,4'b0000,4'b0000,1);
    mk(0,1,4'b0000,'h00,1,0, 1,'h31,1,4'b0000,4'b0000,1);
    mk(0,1,4'b0000,'h00,1,0, 1,'h32,2,4'b0000,4'b0000,1);
    mk(0,1,4'b0000,'h00,1,0, 1,'h33,3,4'b0000,4'b0000,1);
    mk(0,1,4'b0000,'h00,1,0, 0,'h00,0,4'b0000,4'b0000,0);
    // reset mid-stream with three packets buffered
    mk(0,0,4'b0000,'h00,0,0, 0,'h00,0,4'b0000,4'b0000,1);
    mk(0,1,4'b1001,'h40,0,0, 0,'h00,0,4'b0000,4'b0000,1);
    mk(0,1,4'b1001,'h50,0,0, 1,'h40,0,4'b0000,4'b0000,1);
    mk(0,0,4'b1111,'h60,1,0, 0,'h00,0,4'b0000,4'b0000,1);
    mk(0,1,4'b0000,'h00,0,0, 0,'h00,0,4'b0000,4'b0000,1);
    mk(0,1,4'b0000,'h00,1,0, 0,'h00,0,4'b0000,4'b0000,1);
    // fixed priority instance
    mk(1,0,4'b0000,'h00,0,0, 0,'h00,0,4'b0000,4'b0000,1);
    mk(1,1,4'b1001,'h40,0,0, 0,'h00,0,4'b0000,4'b0000,1);
    mk(1,1,4'b1001,'h50,0,0, 1,'h40,0,4'b0000,4'b0000,1);
    mk(1,1,4'b0000,'h00,1,0, 1,'h50,0,4'b0000,4'b0000,1);
    mk(1,1,4'b0000,'h00,1,0, 1,'h43,3,4'b0000,4'b0000,1);
    mk(1,1,4'b0000,'h00,1,0, 1,'h53,3,4'b0000,4'b0000,1);
    mk(1,1,4'b0000,'h00,1,0, 0,'h00,0,4'b0000,4'b0000,0);

    @(negedge clk);
    for (int i = 0; i < tv.size(); i++) begin
      rst_n = tv[i].rst;
      push  = tv[i].push;
      d     = tv[i].d;
      pop   = tv[i].pop;
      clr   = tv[i].clr;
      @(posedge clk);
      @(negedge clk);
      if (tv[i].sel == 1'b0) begin
        ap = bus0.pndng; ad = bus0.data_out;
        as = bus0.src_id; af = bus0.full;
        ao = bus0.overflow;
      end else begin
        ap = bus1.pndng; ad = bus1.data_out;
        as = bus1.src_id; af = bus1.full;
        ao = bus1.overflow;
      end
      chk($sformatf("row%0d pndng", i), PW'(ap), PW'(tv[i].ep));
      chk($sformatf("row%0d full", i), PW'(af), PW'(tv[i].ef));
      chk($sformatf("row%0d overflow", i), PW'(ao), PW'(tv[i].eo));
      if (tv[i].cd) begin
        chk($sformatf("row%0d data_out", i), ad, tv[i].ed);
        chk($sformatf("row%0d src_id", i), PW'(as), PW'(tv[i].es));
      end
    end

    rst_n = 1'b0; push = '0; pop = 1'b0; clr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int n = 0; n < 3000; n++) begin
      pp    = ((n / 300) % 2 == 0) ? 85 : 20;
      rst_n = ($urandom_range(0, 299) != 0);
      push  = CH'($urandom) & CH'($urandom | $urandom);
      d     = {8'($urandom), 32'($urandom)};
      pop   = ($urandom_range(0, 99) < pp);
      clr   = ($urandom_range(0, 39) == 0);
      @(posedge clk);
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        if (m == 0) begin
          ap = bus0.pndng; ad = bus0.data_out;
          as = bus0.src_id; af = bus0.full;
          ao = bus0.overflow;
        end else begin
          ap = bus1.pndng; ad = bus1.data_out;
          as = bus1.src_id; af = bus1.full;
          ao = bus1.overflow;
        end
        for (int c = 0; c < CH; c++)
          mf[c] = (mq[m*CH+c].size() == 4);
        chk($sformatf("rnd%0d m%0d pndng", n, m), PW'(ap), PW'(mv[m]));
        chk($sformatf("rnd%0d m%0d full", n, m), PW'(af), PW'(mf));
        chk($sformatf("rnd%0d m%0d ovf", n, m), PW'(ao), PW'(movf[m]));
        if (mv[m]) begin
          chk($sformatf("rnd%0d m%0d data", n, m), ad, md[m]);
          chk($sformatf("rnd%0d m%0d src", n, m), PW'(as), PW'(ms[m]));
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/mesh_port_arbiter.md
MESH_PORT_ARBITER -- requirements
Module: mesh_port_arbiter

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of terminal input channels merged into one mesh port.
REQ-002 SHALL have parameter pckg_sz, default 40: packet width in bits.
REQ-003 SHALL have parameter fifo_depth, default 4: entries per channel FIFO, any integer >= 2.
REQ-004 SHALL have parameter ARB_MODE, default 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-005 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-007 SHALL have port push  input  CHANNELS  per-channel write strobe.
REQ-008 SHALL have port data_in  input  CHANNELS*pckg_sz  per-channel packet; channel i at bits [i*pckg_sz +: pckg_sz].
REQ-009 SHALL have port full  output  CHANNELS  per-channel FIFO full.
REQ-010 SHALL have port overflow  output  CHANNELS  sticky per-channel drop flag.
REQ-011 SHALL have port clr_ovf  input  1  clears all overflow flags.
REQ-012 SHALL have port pndng  output  1  output packet valid.
REQ-013 SHALL have port data_out  output  pckg_sz  output packet.
REQ-014 SHALL have port src_id  output  $clog2(CHANNELS), minimum 1  channel that supplied data_out.
REQ-015 SHALL have port pop  input  1  consumer acknowledge of data_out.

Function
REQ-016 Each channel SHALL own an independent circular FIFO of fifo_depth entries, with read/write pointers wrapping from fifo_depth-1 to 0 and an occupancy counter 0..fifo_depth.
REQ-017 full[i] SHALL be 1 exactly when occupancy of channel i equals fifo_depth.
REQ-018 push[i] with full[i]=0 SHALL store data_in[i] at the next edge.
REQ-019 push[i] with full[i]=1 SHALL drop the packet and set overflow[i] at the next edge, unless channel i is read in the same cycle, in which case the packet SHALL be stored.
REQ-020 overflow[i] SHALL hold until clr_ovf=1 or reset; clr_ovf takes priority over a same-cycle set.
REQ-021 The output stage SHALL be a two-state machine: EMPTY (pndng=0) and VALID (pndng=1).
REQ-022 In EMPTY with at least one non-empty FIFO: the winner's head SHALL load into data_out/src_id, the winner's FIFO SHALL be read, and the state SHALL go to VALID at the next edge.
REQ-023 In VALID with pop=1 and a non-empty FIFO: the winner SHALL load in the same edge, with no bubble cycle.
REQ-024 In VALID with pop=1 and all FIFOs empty: the state SHALL go to EMPTY.
REQ-025 In VALID with pop=0: data_out and src_id SHALL hold stable.
REQ-026 pop in EMPTY SHALL be ignored.
REQ-027 A packet pushed at edge k into an idle block SHALL be presented with pndng=1 after edge k+1; a FIFO SHALL never bypass its own storage.
REQ-028 Round-robin (ARB_MODE=0): search SHALL start at pointer rr and proceed upward modulo CHANNELS; after each grant, rr SHALL become winner+1 modulo CHANNELS.
REQ-029 Fixed priority (ARB_MODE=1): the lowest-index non-empty channel SHALL win, and rr SHALL be unused.
REQ-030 Arbitration SHALL consider only occupancy registered at the start of the cycle; a same-cycle push SHALL not be visible.
REQ-031 Packet contents SHALL pass through unmodified; the block SHALL not decode headers.
REQ-032 Per-channel ordering SHALL be strictly FIFO, and no packet SHALL be duplicated or lost except through REQ-019 drops.

Reset
REQ-033 When reset=0 at an edge: all FIFOs SHALL empty, pointers and counters go to 0, full=0, overflow=0, pndng=0, data_out=0, src_id=0, rr=0, and the state goes to EMPTY.
REQ-034 Reset mid-operation SHALL discard all stored and presented packets.
REQ-035 push and pop SHALL be ignored while reset=0.

Verification
REQ-036 Single packet: release reset, push[2]=1 with data 40'hA5 for one cycle -> pndng=1 one edge later, data_out=40'hA5, src_id=2; pop one cycle -> pndng=0 next edge.
REQ-037 Round-robin: preload channels 0..3 with two packets each, pop held at 1 -> src_id sequence 0,1,2,3,0,1,2,3, pndng continuously 1, then pndng=0.
REQ-038 Fixed priority (ARB_MODE=1): channels 0 and 3 each preloaded with 2 packets, pop=1 -> src_id sequence 0,0,3,3.
REQ-039 Overflow: five pushes to channel 1 with pop=0 (fifo_depth=4; the first is absorbed into the output stage) -> no drop, full[1]=1; a sixth push -> overflow[1]=1 and the packet is dropped; clr_ovf -> overflow[1]=0.
REQ-040 Full with simultaneous read: channel 0 full while pndng=1 with data from channel 0; pop=1 and push[0]=1 in the same cycle -> packet accepted, overflow[0] stays 0.
REQ-041 Reset mid-stream: reset=0 while pndng=1 and FIFOs hold 3 packets -> pndng=0, data_out=0, full=0 after one edge, with no stale packet after reset is released.
